dp_alu_stage: RTL
=================

# dp_alu_stage

Registered data-processing ALU stage sitting directly downstream of the register-controlled barrel shifter in the execute path. It consumes the shifted second operand and its shifter carry-out, together with the first register operand and a 4-bit ARM data-processing opcode. It computes the result and NZCV flags, and holds them in an output register behind a valid/ready handshake. It owns the architectural NZCV flag register used by carry-in opcodes.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operation valid.
- in_ready  output  1  stage can accept this cycle.
- opcode  input  4  ARM DP opcode: AND 0, EOR 1, SUB 2, RSB 3, ADD 4, ADC 5, SBC 6, RSC 7, TST 8, TEQ 9, CMP A, CMN B, ORR C, MOV D, BIC E, MVN F.
- set_flags  input  1  S bit; update NZCV on accept.
- Rn  input  WIDTH  first operand.
- Op2  input  WIDTH  shifted operand from shifter (its Rd).
- shifter_carry  input  1  shifter carry-out.
- out_valid  output  1  Result/write_en valid.
- out_ready  input  1  downstream accepts.
- Result  output  WIDTH  registered result.
- write_en  output  1  result must be written back; 0 for opcodes 8–B.
- flags  output  4  architectural NZCV {N,Z,C,V}.

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (single output register, pass-through ready).
- On accept: Result, write_en are loaded and out_valid is set to 1. Otherwise, out_valid is cleared on out_valid && out_ready. Result is held stable while out_valid && !out_ready.
- Arithmetic ops are computed as 33-bit sums:
  - SUB = Rn + ~Op2 + 1.
  - RSB = Op2 + ~Rn + 1.
  - ADC = Rn + Op2 + C.
  - SBC = Rn + ~Op2 + C.
  - RSC = Op2 + ~Rn + C.
  - CMP is SUB; CMN is ADD.
- C is the registered flag at the accept cycle.
- Arithmetic flags (when set_flags):
  - N = res[31].
  - Z = (res == 0).
  - C = bit 32 of the sum. For subtract forms this is NOT borrow.
  - V = signed overflow of the two addends.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - N and Z come from the result.
  - C = shifter_carry.
  - V is unchanged.
- set_flags = 0: flags unchanged.
- Opcodes 8–B update flags regardless of set_flags (compare ops always set flags) and produce write_en = 0. Result still carries the computed value.
- Flags update in the accept cycle, so the next accepted op sees them (back-to-back ADC chains are correct).
- Reset values: out_valid 0, Result 0, write_en 0, flags 4'b0000. Reset mid-transaction discards the held result.

## Timing
- Latency: 1 cycle, from accept edge to out_valid high.
- Throughput: 1 op/cycle while out_ready = 1.
- Simultaneous accept and drain in the same cycle: the new op replaces the old; out_valid stays 1.
- in_valid with in_ready = 0: no state change. Upstream must hold its inputs.
- flags changes only on an accept edge or on reset.

## Configuration
- DP_ALU_OP_COUNT_EN:
  - Defined: adds output port op_count (32 bits), reset 0, incremented on every accept, wrapping from 0xFFFFFFFF to 0.
  - Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- ADDS: Rn = 0x7FFFFFFF, Op2 = 1, set_flags = 1 -> Result 0x80000000, NZCV = 1001, write_en = 1, out_valid one cycle after accept.
- CMP: Rn = 5, Op2 = 5, set_flags = 0 -> NZCV = 0110, write_en = 0; then SUBS Rn = 0, Op2 = 1 -> Result 0xFFFFFFFF, NZCV = 1000.
- Carry chain: ADDS 0xFFFFFFFF + 1 (C = 1), then ADC Rn = 1, Op2 = 1 back-to-back -> Result 3, flags from ADDS = 0110.
- ANDS: Rn = 0xF0, Op2 = 0x0F, shifter_carry = 1, prior V = 1 -> Result 0, NZCV = 0111.
- Backpressure: out_ready = 0 for 3 cycles after accept -> in_ready = 0 and Result held. Raising out_ready with in_valid = 1 produces a same-cycle accept and replace.
- Assert reset with out_valid = 1 and flags = 1111 -> out_valid, Result and flags go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dp_alu_stage.sv
`default_nettype none
// ============================================================================
// Module      : dp_alu_stage
// Description : Registered ARM data-processing ALU stage that produces Result
//               and the NZCV flags behind a valid/ready output register.
//               Optional feature macro DP_ALU_OP_COUNT_EN adds an op_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] Rn,
    input  logic [WIDTH-1:0] Op2,
    input  logic             shifter_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             write_en,
    output logic [3:0]       flags
`ifdef DP_ALU_OP_COUNT_EN
    ,
    output logic [31:0]      op_count
`endif
);

    localparam logic [3:0] c_OP_AND = 4'h0;
    localparam logic [3:0] c_OP_EOR = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_RSB = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_ADC = 4'h5;
    localparam logic [3:0] c_OP_SBC = 4'h6;
    localparam logic [3:0] c_OP_RSC = 4'h7;
    localparam logic [3:0] c_OP_TST = 4'h8;
    localparam logic [3:0] c_OP_TEQ = 4'h9;
    localparam logic [3:0] c_OP_CMP = 4'hA;
    localparam logic [3:0] c_OP_CMN = 4'hB;
    localparam logic [3:0] c_OP_ORR = 4'hC;
    localparam logic [3:0] c_OP_MOV = 4'hD;
    localparam logic [3:0] c_OP_BIC = 4'hE;
    localparam logic [3:0] c_OP_MVN = 4'hF;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_write_en;
    logic [3:0]       r_flags;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_cin;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_logic_res;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_is_cmp;
    logic             w_accept;
    logic             w_upd_flags;
    logic [3:0]       w_flags_next;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign write_en  = r_write_en;
    assign flags     = r_flags;

    // Every arithmetic form is a single adder; subtracts invert one addend.
    always_comb begin
        w_add_a     = Rn;
        w_add_b     = Op2;
        w_cin       = 1'b0;
        w_is_arith  = 1'b1;
        w_logic_res = Rn & Op2;
        case (opcode)
            c_OP_AND, c_OP_TST: begin
                w_is_arith  = 1'b0;
                w_logic_res = Rn & Op2;
            end
            c_OP_EOR, c_OP_TEQ: begin
                w_is_arith  = 1'b0;
                w_logic_res = Rn ^ Op2;
            end
            c_OP_SUB, c_OP_CMP: begin
                w_add_b = ~Op2;
                w_cin   = 1'b1;
            end
            c_OP_RSB: begin
                w_add_a = Op2;
                w_add_b = ~Rn;
                w_cin   = 1'b1;
            end
            c_OP_ADD, c_OP_CMN: begin
                w_cin = 1'b0;
            end
            c_OP_ADC: begin
                w_cin = r_flags[1];
            end
            c_OP_SBC: begin
                w_add_b = ~Op2;
                w_cin   = r_flags[1];
            end
            c_OP_RSC: begin
                w_add_a = Op2;
                w_add_b = ~Rn;
                w_cin   = r_flags[1];
            end
            c_OP_ORR: begin
                w_is_arith  = 1'b0;
                w_logic_res = Rn | Op2;
            end
            c_OP_MOV: begin
                w_is_arith  = 1'b0;
                w_logic_res = Op2;
            end
            c_OP_BIC: begin
                w_is_arith  = 1'b0;
                w_logic_res = Rn & ~Op2;
            end
            c_OP_MVN: begin
                w_is_arith  = 1'b0;
                w_logic_res = ~Op2;
            end
            default: begin
                w_is_arith = 1'b1;
            end
        endcase
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};
    assign w_res = w_is_arith ? w_sum[WIDTH-1:0] : w_logic_res;
    assign w_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

    assign w_is_cmp     = (opcode[3:2] == 2'b10);
    assign w_upd_flags  = w_accept && (set_flags || w_is_cmp);
    assign w_flags_next = {w_res[WIDTH-1],
                           ~|w_res,
                           w_is_arith ? w_sum[WIDTH] : shifter_carry,
                           w_is_arith ? w_ovf        : r_flags[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_write_en  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_write_en  <= !w_is_cmp;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flags commit at accept so a back-to-back carry-in op sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_upd_flags) begin
            r_flags <= w_flags_next;
        end
    end

`ifdef DP_ALU_OP_COUNT_EN
    logic [31:0] r_op_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_accept) begin
            r_op_count <= r_op_count + 32'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire
